// File: rtl/grayscale_pkg.sv
// Shared constants and types for the packed RGB565-to-grayscale instruction.
// Luma weights, field widths and the FSM state type.
package grayscale_pkg;

  localparam int R_W = 5;
  localparam int G_W = 6;
  localparam int B_W = 5;
  localparam int PIX_W = R_W + G_W + B_W;
  localparam int GRAY_W = 8;
  localparam int ACC_W = 16;

  localparam logic [ACC_W-1:0] GRAY_W_R = 16'd54;
  localparam logic [ACC_W-1:0] GRAY_W_G = 16'd183;
  localparam logic [ACC_W-1:0] GRAY_W_B = 16'd19;
  localparam int GRAY_SHIFT = 8;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  typedef logic [1:0] idx_t;

endpackage

// File: rtl/rgb565_to_gray.sv
// Combinational RGB565 to 8-bit grayscale converter.
// Channels are expanded to 8 bits, weighted, summed and truncated.
module rgb565_to_gray
  import grayscale_pkg::*;
(
  input  logic [PIX_W-1:0]  pixel,
  output logic [GRAY_W-1:0] gray
);

  logic [R_W-1:0] r5;
  logic [G_W-1:0] g6;
  logic [B_W-1:0] b5;
  logic [7:0] r8;
  logic [7:0] g8;
  logic [7:0] b8;
  logic [ACC_W-1:0] acc;

  assign r5 = pixel[15:11];
  assign g6 = pixel[10:5];
  assign b5 = pixel[4:0];

  assign r8 = {r5, r5[4:2]};
  assign g8 = {g6, g6[5:4]};
  assign b8 = {b5, b5[4:2]};

  // Peak is 255*256, so the 16-bit sum never wraps.
  assign acc = GRAY_W_R * {8'd0, r8}
             + GRAY_W_G * {8'd0, g8}
             + GRAY_W_B * {8'd0, b8};

  assign gray = acc[GRAY_SHIFT +: GRAY_W];

endmodule

// File: rtl/grayscale_pack_ise.sv
// Four-pixel RGB565 to packed grayscale custom instruction, one pixel/cycle.
// GRAYSCALE_PACK_BIG_ENDIAN_EN places pixel0 in the MSB lane.
module grayscale_pack_ise
  import grayscale_pkg::*;
#(
  parameter logic [7:0] customInstructionId = 8'd0
) (
  input  logic        clock,
  input  logic        nReset,
  input  logic        start,
  input  logic [7:0]  iseId,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  output logic        done,
  output logic [31:0] result
);

  state_t state_q;
  state_t state_d;
  idx_t   idx_q;
  idx_t   lane;
  logic [31:0] op_a_q;
  logic [31:0] op_b_q;
  logic [31:0] pack_q;
  logic [31:0] pack_d;
  logic [PIX_W-1:0] pix;
  logic [GRAY_W-1:0] gray;
  logic accept;
  logic last;
  logic done_q;
  logic [31:0] result_q;

  assign accept = (state_q == IDLE) && start
                && (iseId == customInstructionId);
  assign last = (state_q == BUSY) && (idx_q == 2'd3);

  always_comb begin
    pix = op_a_q[15:0];
    unique case (idx_q)
      2'd0: pix = op_a_q[15:0];
      2'd1: pix = op_a_q[31:16];
      2'd2: pix = op_b_q[15:0];
      2'd3: pix = op_b_q[31:16];
      default: pix = op_a_q[15:0];
    endcase
  end

  rgb565_to_gray u_conv (
    .pixel (pix),
    .gray  (gray)
  );

`ifdef GRAYSCALE_PACK_BIG_ENDIAN_EN
  assign lane = ~idx_q;
`else
  assign lane = idx_q;
`endif

  always_comb begin
    pack_d = pack_q;
    pack_d[{lane, 3'b000} +: 8] = gray;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = BUSY;
      BUSY: if (last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      idx_q  <= '0;
      op_a_q <= '0;
      op_b_q <= '0;
      pack_q <= '0;
    end else if (accept) begin
      idx_q  <= '0;
      op_a_q <= valueA;
      op_b_q <= valueB;
      pack_q <= '0;
    end else if (state_q == BUSY) begin
      idx_q  <= idx_q + 2'd1;
      pack_q <= pack_d;
    end
  end

  // Result is only non-zero during the single done cycle.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      done_q   <= 1'b0;
      result_q <= '0;
    end else if (last) begin
      done_q   <= 1'b1;
      result_q <= pack_d;
    end else begin
      done_q   <= 1'b0;
      result_q <= '0;
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_grayscale_pack_ise.sv
// Directed bench for grayscale_pack_ise with hand-computed results.
// Expected words follow GRAYSCALE_PACK_BIG_ENDIAN_EN when defined.
module tb_grayscale_pack_ise;

  localparam logic [7:0] ID = 8'd13;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  ise_id;
  logic [31:0] value_a;
  logic [31:0] value_b;
  logic        done;
  logic [31:0] result;

  int total = 0;
  int bad = 0;

`ifdef GRAYSCALE_PACK_BIG_ENDIAN_EN
  localparam logic [31:0] EXP_MIX = 32'h35B612FF;
`else
  localparam logic [31:0] EXP_MIX = 32'hFF12B635;
`endif

  always #5 clk = ~clk;

  grayscale_pack_ise #(
    .customInstructionId (ID)
  ) dut (
    .clock   (clk),
    .nReset  (rst_n),
    .start   (start),
    .iseId   (ise_id),
    .valueA  (value_a),
    .valueB  (value_b),
    .done    (done),
    .result  (result)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [7:0] id);
    @(negedge clk);
    start = 1'b1;
    ise_id = id;
    value_a = a;
    value_b = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts rising edges until done; lat=-1 if it never arrives.
  task automatic wait_done(output int lat, output logic [31:0] res);
    lat = -1;
    res = '0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        res = result;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] exp);
    int lat;
    logic [31:0] res;
    issue(a, b, ID);
    wait_done(lat, res);
    chk({tag, "_lat"}, 32'(lat), 32'd4);
    chk({tag, "_res"}, res, exp);
    @(posedge clk);
    #1;
    chk({tag, "_done_off"}, {31'd0, done}, 32'd0);
    chk({tag, "_res_off"}, result, 32'd0);
  endtask

  initial begin
    int lat;
    int cnt;
    logic [31:0] res;

    rst_n = 1'b0;
    start = 1'b1;
    ise_id = ID;
    value_a = 32'hFFFFFFFF;
    value_b = 32'hFFFFFFFF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_res", result, 32'd0);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
    chk("idle_no_done", 32'(cnt), 32'd0);

    @(negedge clk);
    start = 1'b1;
    ise_id = 8'd47;
    value_a = 32'h07E0F800;
    value_b = 32'hFFFF001F;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (done || result != 0) cnt++;
    end
    chk("id_mismatch", 32'(cnt), 32'd0);

    run_op("mixed", 32'h07E0F800, 32'hFFFF001F, EXP_MIX);
    run_op("white", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op("black", 32'h00000000, 32'h00000000, 32'h00000000);
    run_op("blue2", 32'h001F001F, 32'h00000000,
`ifdef GRAYSCALE_PACK_BIG_ENDIAN_EN
           32'h12120000);
`else
           32'h00001212);
`endif

    issue(32'h07E0F800, 32'hFFFF001F, ID);
    wait_done(lat, res);
    chk("b2b_first_res", res, EXP_MIX);
    @(negedge clk);
    start = 1'b1;
    ise_id = ID;
    value_a = 32'hF800F800;
    value_b = 32'hF800F800;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_gap_done", {31'd0, done}, 32'd0);
    wait_done(lat, res);
    chk("b2b_second_lat", 32'(lat + 1), 32'd5);
    chk("b2b_second_res", res, 32'h35353535);

    issue(32'h07E0F800, 32'hFFFF001F, ID);
    @(posedge clk);
    #1;
    start = 1'b1;
    ise_id = ID;
    value_a = 32'h00000000;
    value_b = 32'h00000000;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat, res);
    chk("busy_lat", 32'(lat), 32'd2);
    chk("busy_res", res, EXP_MIX);
    @(posedge clk);
    #1;
    chk("busy_no_extra", {31'd0, done}, 32'd0);

    issue(32'hFFFFFFFF, 32'hFFFFFFFF, ID);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    cnt = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (done || result != 0) cnt++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
    chk("midrst_no_done", 32'(cnt), 32'd0);
    run_op("after_rst", 32'h07E0F800, 32'hFFFF001F, EXP_MIX);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
